// File: rtl/rarb_pkg.sv
// Shared types for the 4-port ring arbiter: port count, client FSM states and the FIFO entry layout.
package rarb_pkg;
  localparam int NUM_PORTS   = 4;
  localparam int RARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GNT  = 2'd2,
    REL  = 2'd3
  } state_e;

  typedef struct packed {
    logic                   last;
    logic [RARB_DATA_W-1:0] data;
  } rarb_entry_t;
endpackage

// File: rtl/rarb_client_fifo.sv
// Synchronous FIFO with full/empty/level and a head read directly from the registered storage.
// Writes are dropped when full and reads are ignored when empty; reset flushes by clearing the pointers.
module rarb_client_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr,
  input  logic [W-1:0]               i_wr_dat,
  input  logic                       i_rd,
  output logic [W-1:0]               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_wr;
  logic         w_rd;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_wr = i_wr && !o_full;
  assign w_rd = i_rd && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
  end
endmodule

// File: rtl/rarb_client.sv
// Requester agent for one ring-arbiter port: buffers source packets, requests, drives the granted bus, releases per packet.
// Optional request timeout enabled by RARB_CLIENT_TIMEOUT_EN; otherwise REQ waits indefinitely and err_timeout is 0.
module rarb_client
  import rarb_pkg::*;
#(
  parameter int DATA_W      = RARB_DATA_W,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_last,
  output logic              rarb_req,
  input  logic              rarb_ack,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              err_timeout
);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] ALMOST_FULL = LW'(DEPTH-1);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [LW-1:0]   r_pkt_cnt;
  entry_t          w_head;
  logic            w_full;
  logic            w_empty;
  logic [LW-1:0]   w_level;
  logic            w_wr;
  logic            w_rd;
  logic            w_wr_last;
  logic            w_rd_last;
  logic            w_go;
  logic            w_to_hit;

  assign src_ready = !w_full && !reset;
  assign w_wr      = src_valid && src_ready;
  assign w_rd      = bus_valid && bus_ready;
  assign w_wr_last = w_wr && src_last;
  assign w_rd_last = w_rd && w_head.last;

  rarb_client_fifo #(.W(DATA_W+1), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr     (w_wr),
    .i_wr_dat ({src_last, src_data}),
    .i_rd     (w_rd),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level)
  );

  assign rarb_req  = (r_state == REQ) || (r_state == GNT);
  assign bus_valid = (r_state == GNT) && !w_empty;
  assign bus_data  = bus_valid ? w_head.data : '0;
  assign bus_last  = bus_valid && w_head.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_cnt <= '0;
    end else if (w_wr_last && !w_rd_last) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end else if (!w_wr_last && w_rd_last) begin
      r_pkt_cnt <= r_pkt_cnt - 1'b1;
    end
  end

  // IDLE never reads, so look at this cycle's write to raise the request one cycle after it lands.
  assign w_go = (r_pkt_cnt != '0) || w_wr_last || w_full || ((w_level == ALMOST_FULL) && w_wr);

`ifdef RARB_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  assign w_to_hit    = (r_state == REQ) && !rarb_ack && (r_to_cnt == TW'(TIMEOUT_CYC-1));
  assign err_timeout = r_err;

  always_ff @(posedge clk) begin
    if (reset || (r_state != REQ)) r_to_cnt <= '0;
    else                           r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)         r_err <= 1'b0;
    else if (w_to_hit) r_err <= 1'b1;
  end
`else
  assign w_to_hit    = 1'b0;
  // TIMEOUT_CYC stays on the interface so both builds share one parameter list.
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_nxt = REQ;
      REQ: begin
        if (rarb_ack)      w_state_nxt = GNT;
        else if (w_to_hit) w_state_nxt = REL;
      end
      GNT:     if (w_rd_last) w_state_nxt = REL;
      REL:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
endmodule
